// File: rtl/exec_seq_unit.sv
// exec_seq_unit: multi-cycle sequencer for shift-add multiply and single-bit-step shifts/rotate
module exec_seq_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] RD1,
  input  logic [7:0] RD2,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       carry
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [7:0] acc, opb;
  logic [1:0] opr;
  logic [15:0] prod;
  logic cry;
  logic [8:0] sum;
  always_comb begin
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (cnt == 4'd0 ? DONE : RUN) : IDLE;
    sum = {1'b0, prod[15:8]} + (prod[0] ? {1'b0, opb} : 9'd0);
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // ROR's new bit 7 is the old bit 0, so cry tracks both the LSR shift-out and the ROR result msb
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      opb <= '0;
      opr <= '0;
      prod <= '0;
      cry <= 1'b0;
      result <= '0;
      carry <= 1'b0;
    end else if (state == IDLE && start) begin
      acc <= RD1;
      opb <= RD2;
      opr <= op;
      prod <= {8'd0, RD1};
      cry <= 1'b0;
      cnt <= op == 2'b00 ? 4'd8 : {1'b0, RD2[2:0]};
    end else if (state == RUN && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
      prod <= {sum, prod[7:1]};
      acc <= opr == 2'b01 ? {acc[6:0], 1'b0} : opr == 2'b10 ? {1'b0, acc[7:1]} : {acc[0], acc[7:1]};
      cry <= opr == 2'b01 ? acc[7] : acc[0];
    end else if (state == RUN) begin
      result <= opr == 2'b00 ? prod[7:0] : acc;
      carry <= opr == 2'b00 ? |prod[15:8] : cry;
    end
  end
endmodule

// File: tb/tb_exec_seq_unit.sv
// tb_exec_seq_unit: scoreboard bench for exec_seq_unit
module tb_exec_seq_unit;
  logic clk = 0, reset = 1, start = 0;
  logic [1:0] op = 0;
  logic [7:0] RD1 = 0, RD2 = 0;
  logic busy, done, carry;
  logic [7:0] result;
  int total = 0, passed = 0;
  logic [7:0] last_res = 0;
  logic last_cry = 0;
  logic [16:0] sb [$];

  exec_seq_unit dut (.clk(clk), .reset(reset), .start(start), .op(op), .RD1(RD1), .RD2(RD2),
                     .busy(busy), .done(done), .result(result), .carry(carry));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [8:0] model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] t;
    logic [7:0] r;
    int n;
    n = b[2:0];
    case (o)
      2'b00: begin t = 16'(a) * 16'(b); return {|t[15:8], t[7:0]}; end
      2'b01: begin t = {8'd0, a} << n; return {t[8], t[7:0]}; end
      2'b10: begin t = {a, 8'd0} >> n; return {t[7], t[15:8]}; end
      default: begin r = 8'((a >> n) | (a << (8 - n))); return {n != 0 && r[7], r}; end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input bit chg);
    logic [16:0] e;
    int lat;
    bit seen;
    lat = (o == 2'b00 ? 8 : int'(b[2:0])) + 2;
    @(negedge clk);
    op = o; RD1 = a; RD2 = b; start = 1;
    sb.push_back({8'(lat), model(o, a, b)});
    seen = 0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      start = 0;
      if (chg && cyc == 1) begin RD1 = ~a; RD2 = ~b; op = ~o; end
      chk("busy", busy, cyc < lat);
      chk("done", done, cyc == lat);
      if (done) begin
        e = sb.pop_front();
        chk("latency", cyc, e[16:9]);
        chk("result", result, e[7:0]);
        chk("carry", carry, e[8]);
        last_res = result; last_cry = carry;
        seen = 1;
      end else begin
        chk("hold_result", result, last_res);
        chk("hold_carry", carry, last_cry);
      end
    end
    if (!seen) begin chk("timeout", 0, 1); void'(sb.pop_front()); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    reset = 0;
    run_op(2'b00, 8'd13, 8'd11, 0);
    run_op(2'b00, 8'd20, 8'd20, 0);
    run_op(2'b01, 8'h81, 8'd1, 0);
    run_op(2'b11, 8'h01, 8'd3, 0);
    run_op(2'b10, 8'hAA, 8'h08, 0);
    run_op(2'b01, 8'h5A, 8'h08, 0);
    run_op(2'b11, 8'h96, 8'h00, 0);
    run_op(2'b00, 8'hFF, 8'hFF, 1);
    run_op(2'b10, 8'hC3, 8'h07, 1);
    run_op(2'b11, 8'h81, 8'h07, 0);
    for (int i = 0; i < 12; i++)
      run_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), i[0]);
    @(negedge clk);
    op = 2'b00; RD1 = 8'd200; RD2 = 8'd3; start = 1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = cyc == 4;
      if (cyc == 4) begin op = 2'b01; RD1 = 8'h11; RD2 = 8'h02; end
      reset = cyc == 6;
      if (cyc < 6) chk("abort_busy", busy, 1);
      if (cyc >= 7) begin
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_carry", carry, 0);
      end
    end
    last_res = 0; last_cry = 0;
    run_op(2'b01, 8'h81, 8'd1, 0);
    run_op(2'b00, 8'd13, 8'd11, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
